// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } ctrl_state_t;

  // Architectural register index width (x0..x31).
  localparam int REG_W = 5;

  // A flushed IF/ID slot holds addi x0, x0, 0.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // A flushed ID/EX or EX/MEM slot carries all control bits cleared.
  localparam logic BUBBLE_CTRL = 1'b0;

  // Default bound on consecutive data-memory wait cycles.
  localparam int MEM_TIMEOUT_DEF = 16;

endpackage : pipe_ctrl_pkg

// File: rtl/load_use_detect.sv
// Combinational load-use detector: the load in EX writes a register that
// the instruction in ID reads. A load to x0 never creates a dependency.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             uses_rs2,
  output logic             hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = (ex_rd == rs1);
  assign rs2_match = uses_rs2 && (ex_rd == rs2);
  assign hazard    = mem_read && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule : load_use_detect

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage core. Decides every cycle
// whether each pipeline register advances, holds or is flushed, handles
// memory wait states with a timeout trap, and keeps saturating counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] ID_EX_Rd,
  input  logic [REG_W-1:0] IF_ID_Rs1,
  input  logic [REG_W-1:0] IF_ID_Rs2,
  input  logic             IF_ID_UsesRs2,
  input  logic             EX_BranchTaken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             PCSel,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Write,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Write,
  output logic             EX_MEM_Flush,
  output logic             MEM_WB_Write,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_t       state;
  ctrl_state_t       state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_nxt;
  logic              freeze;
  logic              load_use;
  logic              active;
  logic              stall_evt;
  logic              flush_evt;

  load_use_detect u_load_use (
    .mem_read (ID_EX_MemRead),
    .ex_rd    (ID_EX_Rd),
    .rs1      (IF_ID_Rs1),
    .rs2      (IF_ID_Rs2),
    .uses_rs2 (IF_ID_UsesRs2),
    .hazard   (load_use)
  );

  // A pending data access that is not ready this cycle freezes everything.
  assign freeze = dmem_req && !dmem_ready;

  // RUN and MEM_WAIT share one priority list; INIT and ERROR count nothing.
  assign active    = (state == ST_RUN) || (state == ST_MEM_WAIT);
  // A branch flushes the dependent instruction, so it hides the load-use stall.
  assign stall_evt = active && (freeze || (load_use && !EX_BranchTaken));
  assign flush_evt = active && !freeze && EX_BranchTaken;

  // Mealy control outputs: freeze > taken branch > load-use > advance.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    PCWrite      = 1'b0;
    PCSel        = 1'b0;
    IF_ID_Write  = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Write  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Write = 1'b0;
    EX_MEM_Flush = 1'b0;
    MEM_WB_Write = 1'b0;
    unique case (state)
      ST_INIT: begin
        IF_ID_Flush  = 1'b1;
        ID_EX_Flush  = 1'b1;
        EX_MEM_Flush = 1'b1;
      end
      ST_RUN, ST_MEM_WAIT: begin
        if (freeze) begin
          // Everything holds; the defaults already say so.
        end else if (EX_BranchTaken) begin
          // Redirect fetch and squash the two younger instructions.
          PCWrite      = 1'b1;
          PCSel        = 1'b1;
          IF_ID_Write  = 1'b1;
          IF_ID_Flush  = 1'b1;
          ID_EX_Write  = 1'b1;
          ID_EX_Flush  = 1'b1;
          EX_MEM_Write = 1'b1;
          MEM_WB_Write = 1'b1;
        end else if (load_use) begin
          // Hold PC and IF/ID one cycle; insert a bubble into EX.
          ID_EX_Write  = 1'b1;
          ID_EX_Flush  = 1'b1;
          EX_MEM_Write = 1'b1;
          MEM_WB_Write = 1'b1;
        end else begin
          PCWrite      = 1'b1;
          IF_ID_Write  = 1'b1;
          ID_EX_Write  = 1'b1;
          EX_MEM_Write = 1'b1;
          MEM_WB_Write = 1'b1;
        end
      end
      default: begin
        // ST_ERROR: the pipeline stays frozen until reset.
      end
    endcase
  end

  // Next-state and memory-wait counter.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      ST_INIT: state_nxt = ST_RUN;
      ST_RUN: begin
        if (freeze) begin
          state_nxt    = ST_MEM_WAIT;
          wait_cnt_nxt = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (freeze) begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
          if (wait_cnt == WAIT_LAST) state_nxt = ST_ERROR;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_ERROR;
    endcase
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      state       <= ST_INIT;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      mem_timeout <= mem_timeout || (state_nxt == ST_ERROR);
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. A second instance with 4-bit
// counters shares the stimulus and is used for the saturation check.
module tb_pipeline_hazard_ctrl;

  // Control bundle bit order:
  // {PCWrite, PCSel, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush,
  //  EX_MEM_Write, EX_MEM_Flush, MEM_WB_Write}
  localparam logic [8:0] C_INIT = 9'b0_0_0_1_0_1_0_1_0;
  localparam logic [8:0] C_RUN  = 9'b1_0_1_0_1_0_1_0_1;
  localparam logic [8:0] M_WR   = 9'b1_0_1_0_1_0_1_0_1;
  localparam logic [8:0] M_LU   = 9'b1_0_1_0_0_1_1_0_1;
  localparam logic [8:0] E_LU   = 9'b0_0_0_0_0_1_1_0_1;
  localparam logic [8:0] M_BR   = 9'b1_1_0_1_0_1_1_0_1;
  localparam logic [8:0] E_BR   = 9'b1_1_0_1_0_1_1_0_1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, uses_rs2, branch, dmem_req, dmem_ready;
  logic [4:0]  ex_rd, rs1, rs2;

  logic        pc_write, pc_sel, ifid_wr, ifid_fl, idex_wr, idex_fl;
  logic        exmem_wr, exmem_fl, memwb_wr, mem_timeout;
  logic [31:0] stall_cnt, flush_cnt;
  logic [8:0]  ctl;

  logic        s_pc_write, s_pc_sel, s_ifid_wr, s_ifid_fl, s_idex_wr, s_idex_fl;
  logic        s_exmem_wr, s_exmem_fl, s_memwb_wr, s_mem_timeout;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_write, pc_sel, ifid_wr, ifid_fl, idex_wr, idex_fl,
                exmem_wr, exmem_fl, memwb_wr};

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ID_EX_MemRead(mem_read), .ID_EX_Rd(ex_rd), .IF_ID_Rs1(rs1),
    .IF_ID_Rs2(rs2), .IF_ID_UsesRs2(uses_rs2), .EX_BranchTaken(branch),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PCWrite(pc_write), .PCSel(pc_sel), .IF_ID_Write(ifid_wr),
    .IF_ID_Flush(ifid_fl), .ID_EX_Write(idex_wr), .ID_EX_Flush(idex_fl),
    .EX_MEM_Write(exmem_wr), .EX_MEM_Flush(exmem_fl), .MEM_WB_Write(memwb_wr),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .ID_EX_MemRead(mem_read), .ID_EX_Rd(ex_rd), .IF_ID_Rs1(rs1),
    .IF_ID_Rs2(rs2), .IF_ID_UsesRs2(uses_rs2), .EX_BranchTaken(branch),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PCWrite(s_pc_write), .PCSel(s_pc_sel), .IF_ID_Write(s_ifid_wr),
    .IF_ID_Flush(s_ifid_fl), .ID_EX_Write(s_idex_wr), .ID_EX_Flush(s_idex_fl),
    .EX_MEM_Write(s_exmem_wr), .EX_MEM_Flush(s_exmem_fl),
    .MEM_WB_Write(s_memwb_wr), .mem_timeout(s_mem_timeout),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_read   = 1'b0;
    uses_rs2   = 1'b0;
    branch     = 1'b0;
    dmem_req   = 1'b0;
    dmem_ready = 1'b0;
    ex_rd      = 5'd0;
    rs1        = 5'd0;
    rs2        = 5'd0;
  endtask

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;

    // Reset state and release: one INIT cycle, then RUN.
    tick(); tick();
    #4 check("rst_ctl", 32'(ctl), 32'(C_INIT));
    check("rst_stall", stall_cnt, 0);
    check("rst_flush", flush_cnt, 0);
    check("rst_timeout", 32'(mem_timeout), 0);
    tick(); rst_n = 1'b1;
    #4 check("init_ctl", 32'(ctl), 32'(C_INIT));
    tick();
    #4 check("run_ctl", 32'(ctl), 32'(C_RUN));

    // Load-use through rs2.
    tick(); mem_read = 1'b1; ex_rd = 5'd5; rs1 = 5'd3; rs2 = 5'd5; uses_rs2 = 1'b1;
    #4 check("lu_rs2", 32'(ctl & M_LU), 32'(E_LU));
    tick(); mem_read = 1'b0;
    check("lu_cnt", stall_cnt, 1);
    #4 check("lu_clear", 32'(ctl), 32'(C_RUN));
    // Load to x0 never stalls.
    tick(); mem_read = 1'b1; ex_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    #4 check("lu_x0", 32'(ctl), 32'(C_RUN));
    tick();
    check("lu_x0_cnt", stall_cnt, 1);
    // Load-use through rs1; rs2 match ignored when rs2 is unused.
    ex_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd1; uses_rs2 = 1'b0;
    #4 check("lu_rs1", 32'(ctl & M_LU), 32'(E_LU));
    tick(); rs1 = 5'd1; rs2 = 5'd7;
    #4 check("lu_rs2_unused", 32'(ctl), 32'(C_RUN));
    tick();
    check("lu_cnt2", stall_cnt, 2);

    // Branch beats load-use.
    rs1 = 5'd7; branch = 1'b1;
    #4 check("br_lu", 32'(ctl & M_BR), 32'(E_BR));
    tick(); branch = 1'b0; mem_read = 1'b0;
    check("br_flush_cnt", flush_cnt, 1);
    check("br_stall_cnt", stall_cnt, 2);

    // Memory wait of 3 cycles with a taken branch pending.
    dmem_req = 1'b1; dmem_ready = 1'b0; branch = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #4 check("mw_freeze", 32'(ctl), 0);
      tick();
    end
    dmem_ready = 1'b1;
    #4 check("mw_branch", 32'(ctl & M_BR), 32'(E_BR));
    tick(); clear_inputs();
    check("mw_stall_cnt", stall_cnt, 5);
    check("mw_flush_cnt", flush_cnt, 2);

    // 15 wait cycles is one short of the trap.
    dmem_req = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    dmem_ready = 1'b1;
    #4 check("w15_ready", 32'(ctl), 32'(C_RUN));
    check("w15_timeout", 32'(mem_timeout), 0);
    tick(); clear_inputs();
    check("w15_stall_cnt", stall_cnt, 20);
    #4 check("w15_run", 32'(ctl), 32'(C_RUN));

    // 16 wait cycles traps into ERROR.
    tick(); dmem_req = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    check("to_flag", 32'(mem_timeout), 1);
    check("to_stall_cnt", stall_cnt, 36);
    dmem_req = 1'b0;
    #4 check("to_writes", 32'(ctl & M_WR), 0);
    tick(); tick();
    check("to_sticky", 32'(mem_timeout), 1);
    check("to_no_count", stall_cnt, 36);
    #4 check("to_writes_hold", 32'(ctl & M_WR), 0);

    // Asynchronous reset mid-operation.
    rst_n = 1'b0;
    #1 check("ar_timeout", 32'(mem_timeout), 0);
    check("ar_stall", stall_cnt, 0);
    check("ar_flush", flush_cnt, 0);
    check("ar_ctl", 32'(ctl), 32'(C_INIT));
    tick(); rst_n = 1'b1;
    #4 check("ar_init", 32'(ctl), 32'(C_INIT));
    tick();
    #4 check("ar_run", 32'(ctl), 32'(C_RUN));

    // Saturation: 20 load-use stalls.
    for (int i = 0; i < 20; i++) begin
      tick(); mem_read = 1'b1; ex_rd = 5'd9; rs1 = 5'd9;
      tick(); mem_read = 1'b0;
    end
    tick();
    check("sat_stall4", 32'(s_stall_cnt), 15);
    check("sat_stall32", stall_cnt, 20);
    check("sat_flush4", 32'(s_flush_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl
